// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller: walks an instruction through NUM_STAGES stages,
// skipping stages the decoder marks, stalling memory stages, with halt/resume.
module stage_sequencer #(
  parameter int                    NUM_STAGES     = 5,
  parameter logic [NUM_STAGES-1:0] MEM_STAGE_MASK = 5'b01001,
  parameter int                    CNT_W          = 32,
  parameter int                    STAGE_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] skip_mask,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [STAGE_W-1:0]    stage,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic                  is_fetch,
  output logic                  is_pc_update,
  output logic                  stalled,
  output logic                  retire,
  output logic                  halted,
  output logic [CNT_W-1:0]      retired_count,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t             state_r, state_next;
  logic [STAGE_W-1:0] stage_r, stage_next;
  logic [CNT_W-1:0]   retired_r, retired_next;
  logic [CNT_W-1:0]   cycle_r, cycle_next;
  logic               running_s;
  logic               mem_wait_s;

  // Fetch always goes to decode (skip_mask is not valid yet); the last stage
  // wraps to fetch; otherwise take the first unskipped stage, PC update always.
  function automatic logic [STAGE_W-1:0] next_stage_f(
    input logic [STAGE_W-1:0]    cur,
    input logic [NUM_STAGES-1:0] skip
  );
    logic [STAGE_W-1:0] nxt;
    logic               found;
    logic               hit;
    nxt   = '0;
    found = 1'b0;
    if (cur == '0) begin
      nxt = STAGE_W'(1);
    end else if (cur == LAST_STAGE) begin
      nxt = '0;
    end else begin
      for (int t = 2; t < NUM_STAGES; t++) begin
        hit   = !found && (t > int'(cur)) && ((t == NUM_STAGES - 1) || !skip[t]);
        nxt   = hit ? STAGE_W'(t) : nxt;
        found = found | hit;
      end
    end
    return nxt;
  endfunction

  // Stage strobes decoded from registered state and mem_ready; rst gates the
  // stall so a reset taken mid-stall drops it before the next edge.
  always_comb begin
    running_s     = (state_r == S_RUN);
    mem_wait_s    = running_s && rst && MEM_STAGE_MASK[stage_r] && !mem_ready;
    stalled       = mem_wait_s;
    is_fetch      = running_s && (stage_r == '0);
    is_pc_update  = running_s && (stage_r == LAST_STAGE) && !mem_wait_s;
    retire        = is_pc_update;
    halted        = (state_r == S_HALTED);
    stage         = stage_r;
    retired_count = retired_r;
    cycle_count   = cycle_r;
    if (running_s) begin
      stage_onehot = NUM_STAGES'(1) << stage_r;
    end else begin
      stage_onehot = '0;
    end
  end

  // RUN/HALTED transitions, stage stepping and counter updates.
  always_comb begin
    state_next   = state_r;
    stage_next   = stage_r;
    retired_next = retired_r;
    cycle_next   = cycle_r;
    case (state_r)
      S_RUN: begin
        cycle_next = cycle_r + CNT_W'(1);
        if (mem_wait_s) begin
          stage_next = stage_r;
        end else begin
          stage_next = next_stage_f(stage_r, skip_mask);
        end
        if (retire) begin
          retired_next = retired_r + CNT_W'(1);
          if (halt_req) begin
            state_next = S_HALTED;
          end else begin
            state_next = S_RUN;
          end
        end else begin
          retired_next = retired_r;
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_next = S_RUN;
          stage_next = '0;
        end else begin
          state_next = S_HALTED;
        end
      end
      default: begin
        state_next = S_RUN;
        stage_next = '0;
      end
    endcase
  end

  // State, stage and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_RUN;
      stage_r   <= '0;
      retired_r <= '0;
      cycle_r   <= '0;
    end else begin
      state_r   <= state_next;
      stage_r   <= stage_next;
      retired_r <= retired_next;
      cycle_r   <= cycle_next;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  skip_mask;
  logic        mem_ready, halt_req, resume;
  logic [2:0]  stage, stage_w;
  logic [4:0]  stage_onehot, stage_onehot_w;
  logic        is_fetch, is_pc_update, stalled, retire, halted;
  logic        is_fetch_w, is_pc_update_w, stalled_w, retire_w, halted_w;
  logic [31:0] retired_count, cycle_count;
  logic [3:0]  retired_count_w, cycle_count_w;

  stage_sequencer dut (
    .clk(clk), .rst(rst), .skip_mask(skip_mask), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .stage(stage), .stage_onehot(stage_onehot),
    .is_fetch(is_fetch), .is_pc_update(is_pc_update), .stalled(stalled),
    .retire(retire), .halted(halted), .retired_count(retired_count),
    .cycle_count(cycle_count)
  );

  stage_sequencer #(.CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .skip_mask(skip_mask), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .stage(stage_w), .stage_onehot(stage_onehot_w),
    .is_fetch(is_fetch_w), .is_pc_update(is_pc_update_w), .stalled(stalled_w),
    .retire(retire_w), .halted(halted_w), .retired_count(retired_count_w),
    .cycle_count(cycle_count_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stage;
    logic        stalled;
    logic        retire;
    logic        halted;
    logic [31:0] rcnt;
    logic [31:0] ccnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_cyc = 32'd0;
  int          seq_all[3] = '{0, 1, 4};
  int          seq_mid[4] = '{0, 1, 3, 4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] oh;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      n_vec++;
      oh = e.halted ? 5'b00000 : (5'b00001 << e.stage);
      chk("stage",         32'(stage),           32'(e.stage));
      chk("stage_onehot",  32'(stage_onehot),    32'(oh));
      chk("is_fetch",      32'(is_fetch),        32'(!e.halted && e.stage == 3'd0));
      chk("is_pc_update",  32'(is_pc_update),    32'(!e.halted && e.stage == 3'd4 && !e.stalled));
      chk("stalled",       32'(stalled),         32'(e.stalled));
      chk("retire",        32'(retire),          32'(e.retire));
      chk("halted",        32'(halted),          32'(e.halted));
      chk("retired_count", retired_count,        e.rcnt);
      chk("cycle_count",   cycle_count,          e.ccnt);
      chk("wrap_retired",  32'(retired_count_w), 32'(e.rcnt[3:0]));
      chk("wrap_cycle",    32'(cycle_count_w),   32'(e.ccnt[3:0]));
    end
  end

  task automatic step(input logic [4:0] sk, input logic mr, input logic hr, input logic rs,
                      input int st, input logic e_stall, input logic e_ret, input logic e_halt);
    exp_t e;
    skip_mask = sk;
    mem_ready = mr;
    halt_req  = hr;
    resume    = rs;
    e.stage   = 3'(st);
    e.stalled = e_stall;
    e.retire  = e_ret;
    e.halted  = e_halt;
    e.rcnt    = m_ret;
    e.ccnt    = m_cyc;
    sb.push_back(e);
    if (rst) begin
      if (!e_halt) m_cyc = m_cyc + 32'd1;
      if (e_ret)   m_ret = m_ret + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t er;
    rst = 1'b0; skip_mask = 5'b00000; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset with mem_ready low: fetch shown, no stall
    step(5'b00000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++)
      step(5'b00000, 1'b1, 1'b0, 1'b0, i % 5, 1'b0, (i % 5) == 4, 1'b0);

    // Skip all: stage 3 is a memory stage but is skipped, so mem_ready=0 must not stall
    for (int i = 0; i < 9; i++)
      step(5'b11111, seq_all[i % 3] == 0, 1'b0, 1'b0, seq_all[i % 3], 1'b0, seq_all[i % 3] == 4, 1'b0);

    for (int i = 0; i < 8; i++)
      step(5'b00100, 1'b1, 1'b0, 1'b0, seq_mid[i % 4], 1'b0, seq_mid[i % 4] == 4, 1'b0);

    step(5'b00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    repeat (3) step(5'b00000, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);

    step(5'b00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    repeat (10) step(5'b00000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(5'b00000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(5'b00000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);

    step(5'b00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    // Reset dropped between edges while still stalled in stage 3
    #1;
    rst = 1'b0;
    m_ret = 32'd0;
    m_cyc = 32'd0;
    er.stage = 3'd0; er.stalled = 1'b0; er.retire = 1'b0; er.halted = 1'b0;
    er.rcnt = 32'd0; er.ccnt = 32'd0;
    sb.push_back(er);
    @(negedge clk);
    #2;
    rst = 1'b1;
    mem_ready = 1'b1;
    m_cyc = 32'd1;
    @(posedge clk);
    #1;

    step(5'b11111, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(5'b11111, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 51; i++)
      step(5'b11111, 1'b1, 1'b0, 1'b0, seq_all[i % 3], 1'b0, seq_all[i % 3] == 4, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
